pipeline_hazard_ctrl: RTL and testbench

- Central control for the 5-stage pipeline latches: IF/ID (fetch/decode), ID/EX, EX/MEM and MEM/WB.
- Produces per-latch enable/flush and PC enable from I-cache/D-cache hits, load-use detection, EX-resolved branches/jumps and halt.
- Runs a small halt-drain FSM and a saturating stall-cycle counter.
- Sits beside the datapath. Each latch block updates on CLK when en=1, loading zero (bubble) if flush=1, otherwise loading its inputs.

---
 rtl/cpu_types_pkg.sv | 34 +++
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_detect.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register/word widths, hazard-controller state encoding and
// the bundle of per-latch pipeline control strobes.
package cpu_types_pkg;

    localparam int REGADDR_W  = 5;
    localparam int WORD_W     = 32;
    localparam int STALLCNT_W = 16;

    typedef logic [REGADDR_W-1:0] regbits_t;
    typedef logic [WORD_W-1:0]    word_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } hzd_state_t;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic fd_flush;
        logic de_en;
        logic de_flush;
        logic em_en;
        logic em_flush;
        logic mw_en;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FROZEN = '0;
    localparam pipe_ctrl_t CTRL_FLOW   = '{pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b0,
                                           de_en: 1'b1, de_flush: 1'b0, em_en: 1'b1,
                                           em_flush: 1'b0, mw_en: 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the hazard controller and the datapath: hazard sources in,
// latch/PC strobes and status out.
interface hazard_ctrl_if #(
    parameter int REGADDR_W  = 5,
    parameter int STALLCNT_W = 16
);
    logic                  ihit;
    logic                  dhit;
    logic [REGADDR_W-1:0]  id_rs;
    logic [REGADDR_W-1:0]  id_rt;
    logic                  ex_memread;
    logic [REGADDR_W-1:0]  ex_wsel;
    logic                  ex_pcsrc;
    logic                  mem_dren;
    logic                  mem_dwen;
    logic                  mem_halt;

    logic                  pc_en;
    logic                  fd_en;
    logic                  fd_flush;
    logic                  de_en;
    logic                  de_flush;
    logic                  em_en;
    logic                  em_flush;
    logic                  mw_en;
    logic                  halt;
    logic [STALLCNT_W-1:0] stall_cycles;

    modport hc (
        input  ihit, dhit, id_rs, id_rt, ex_memread, ex_wsel, ex_pcsrc,
               mem_dren, mem_dwen, mem_halt,
        output pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush,
               mw_en, halt, stall_cycles
    );

    modport tb (
        output ihit, dhit, id_rs, id_rt, ex_memread, ex_wsel, ex_pcsrc,
               mem_dren, mem_dwen, mem_halt,
        input  pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush,
               mw_en, halt, stall_cycles
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard sources: load-use between EX load and ID operands, and
// data-cache wait on an outstanding MEM access.
module hazard_detect #(
    parameter int REGADDR_W = 5
) (
    input  logic                 ex_memread_i,
    input  logic [REGADDR_W-1:0] ex_wsel_i,
    input  logic [REGADDR_W-1:0] id_rs_i,
    input  logic [REGADDR_W-1:0] id_rt_i,
    input  logic                 mem_dren_i,
    input  logic                 mem_dwen_i,
    input  logic                 dhit_i,
    output logic                 loaduse_o,
    output logic                 memwait_o
);

    // Register 0 is hardwired to zero, so a load into it never creates a dependency.
    assign loaduse_o = ex_memread_i && (ex_wsel_i != '0) &&
                       ((ex_wsel_i == id_rs_i) || (ex_wsel_i == id_rt_i));

    assign memwait_o = (mem_dren_i || mem_dwen_i) && !dhit_i;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch/PC control with halt-drain FSM and a saturating stall counter.
// Strobes are combinational from state and hazards; halt and the counter are registered.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REGADDR_W  = cpu_types_pkg::REGADDR_W,
    parameter int STALLCNT_W = cpu_types_pkg::STALLCNT_W
) (
    input  logic       CLK,
    input  logic       RST,
    hazard_ctrl_if.hc  bus
);

    hzd_state_t            state_q, state_d;
    logic                  halt_q, halt_d;
    logic [STALLCNT_W-1:0] stall_q, stall_d;
    pipe_ctrl_t            ctrl;
    logic                  loaduse, memwait;

    hazard_detect #(.REGADDR_W(REGADDR_W)) u_detect (
        .ex_memread_i (bus.ex_memread),
        .ex_wsel_i    (bus.ex_wsel),
        .id_rs_i      (bus.id_rs),
        .id_rt_i      (bus.id_rt),
        .mem_dren_i   (bus.mem_dren),
        .mem_dwen_i   (bus.mem_dwen),
        .dhit_i       (bus.dhit),
        .loaduse_o    (loaduse),
        .memwait_o    (memwait)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        ctrl    = CTRL_FROZEN;
        unique case (state_q)
            RUN: begin
                if (memwait) begin
                    ctrl = CTRL_FROZEN;
                end else if (bus.ex_pcsrc) begin
                    ctrl          = CTRL_FLOW;
                    ctrl.fd_flush = 1'b1;
                    ctrl.de_flush = 1'b1;
                end else if (loaduse) begin
                    ctrl          = CTRL_FLOW;
                    ctrl.pc_en    = 1'b0;
                    ctrl.fd_en    = 1'b0;
                    ctrl.de_flush = 1'b1;
                end else if (!bus.ihit) begin
                    ctrl          = CTRL_FLOW;
                    ctrl.pc_en    = 1'b0;
                    ctrl.fd_flush = 1'b1;
                end else begin
                    ctrl = CTRL_FLOW;
                end
                if (bus.mem_halt && !memwait) state_d = DRAIN;
            end
            DRAIN: begin
                // Bubble the front of the pipe while the halt itself moves into WB.
                ctrl          = CTRL_FLOW;
                ctrl.pc_en    = 1'b0;
                ctrl.fd_flush = 1'b1;
                ctrl.de_flush = 1'b1;
                ctrl.em_flush = 1'b1;
                state_d       = HALTED;
            end
            HALTED: begin
                ctrl = CTRL_FROZEN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        halt_d  = (state_d == HALTED);
        stall_d = stall_q;
        if (state_q == RUN && !ctrl.pc_en && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            stall_q <= stall_d;
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.fd_en        = ctrl.fd_en;
    assign bus.fd_flush     = ctrl.fd_flush;
    assign bus.de_en        = ctrl.de_en;
    assign bus.de_flush     = ctrl.de_flush;
    assign bus.em_en        = ctrl.em_en;
    assign bus.em_flush     = ctrl.em_flush;
    assign bus.mw_en        = ctrl.mw_en;
    assign bus.halt         = halt_q;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazard priorities, halt drain, reset
// recovery, and counter saturation on a second narrow-counter instance.
module tb_pipeline_hazard_ctrl;

    // Control vector order: {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en}
    localparam logic [7:0] C_FLOW    = 8'b1101_0101;
    localparam logic [7:0] C_FROZEN  = 8'b0000_0000;
    localparam logic [7:0] C_LOADUSE = 8'b0001_1101;
    localparam logic [7:0] C_BRANCH  = 8'b1111_1101;
    localparam logic [7:0] C_IMISS   = 8'b0111_0101;
    localparam logic [7:0] C_DRAIN   = 8'b0111_1111;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic RST2 = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_if #(.REGADDR_W(5), .STALLCNT_W(16)) bus  ();
    hazard_ctrl_if #(.REGADDR_W(5), .STALLCNT_W(4))  bus2 ();

    pipeline_hazard_ctrl #(.REGADDR_W(5), .STALLCNT_W(16)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.hc)
    );

    pipeline_hazard_ctrl #(.REGADDR_W(5), .STALLCNT_W(4)) u_sat (
        .CLK (CLK),
        .RST (RST2),
        .bus (bus2.hc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_vec();
        return {bus.pc_en, bus.fd_en, bus.fd_flush, bus.de_en, bus.de_flush,
                bus.em_en, bus.em_flush, bus.mw_en};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ihit = 1'b1;       bus.dhit = 1'b0;
        bus.id_rs = '0;        bus.id_rt = '0;
        bus.ex_memread = 1'b0; bus.ex_wsel = '0;
        bus.ex_pcsrc = 1'b0;   bus.mem_dren = 1'b0;
        bus.mem_dwen = 1'b0;   bus.mem_halt = 1'b0;
    endtask

    initial begin
        idle_inputs();
        bus2.ihit = 1'b0;       bus2.dhit = 1'b0;
        bus2.id_rs = '0;        bus2.id_rt = '0;
        bus2.ex_memread = 1'b0; bus2.ex_wsel = '0;
        bus2.ex_pcsrc = 1'b0;   bus2.mem_dren = 1'b0;
        bus2.mem_dwen = 1'b0;   bus2.mem_halt = 1'b0;

        // Reset for two edges
        step();
        step();
        RST = 1'b0;
        #1;
        check("rst_halt", 32'(bus.halt), 32'd0);
        check("rst_stall", 32'(bus.stall_cycles), 32'd0);
        check("rst_ctrl", 32'(ctrl_vec()), 32'(C_FLOW));

        // Load-use on rt
        bus.ex_memread = 1'b1; bus.ex_wsel = 5'd5; bus.id_rt = 5'd5;
        #1;
        check("lu_rt_ctrl", 32'(ctrl_vec()), 32'(C_LOADUSE));
        step();
        check("lu_rt_stall", 32'(bus.stall_cycles), 32'd1);

        // Destination r0 never stalls
        bus.ex_wsel = 5'd0; bus.id_rt = 5'd0; bus.id_rs = 5'd0;
        #1;
        check("lu_r0_ctrl", 32'(ctrl_vec()), 32'(C_FLOW));
        step();
        check("lu_r0_stall", 32'(bus.stall_cycles), 32'd1);

        // Load-use on rs, then a non-matching destination
        bus.ex_wsel = 5'd7; bus.id_rs = 5'd7; bus.id_rt = 5'd2;
        #1;
        check("lu_rs_ctrl", 32'(ctrl_vec()), 32'(C_LOADUSE));
        step();
        check("lu_rs_stall", 32'(bus.stall_cycles), 32'd2);
        bus.ex_wsel = 5'd3;
        #1;
        check("lu_miss_ctrl", 32'(ctrl_vec()), 32'(C_FLOW));
        step();
        bus.ex_memread = 1'b0;

        // Memwait overrides a pending branch for three cycles
        bus.mem_dren = 1'b1; bus.dhit = 1'b0; bus.ex_pcsrc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_br_ctrl", 32'(ctrl_vec()), 32'(C_FROZEN));
            step();
        end
        check("mw_br_stall", 32'(bus.stall_cycles), 32'd5);
        bus.dhit = 1'b1;
        #1;
        check("mw_br_release", 32'(ctrl_vec()), 32'(C_BRANCH));
        step();
        check("mw_br_stall2", 32'(bus.stall_cycles), 32'd5);
        bus.mem_dren = 1'b0; bus.dhit = 1'b0; bus.ex_pcsrc = 1'b0;

        // Store wait also freezes
        bus.mem_dwen = 1'b1;
        #1;
        check("mw_store_ctrl", 32'(ctrl_vec()), 32'(C_FROZEN));
        step();
        check("mw_store_stall", 32'(bus.stall_cycles), 32'd6);
        bus.mem_dwen = 1'b0;

        // Branch wins over I-miss and does not count as a stall
        bus.ex_pcsrc = 1'b1; bus.ihit = 1'b0;
        #1;
        check("br_imiss_ctrl", 32'(ctrl_vec()), 32'(C_BRANCH));
        step();
        check("br_imiss_stall", 32'(bus.stall_cycles), 32'd6);
        bus.ex_pcsrc = 1'b0;
        #1;
        check("imiss_ctrl", 32'(ctrl_vec()), 32'(C_IMISS));
        step();
        check("imiss_stall", 32'(bus.stall_cycles), 32'd7);
        bus.ihit = 1'b1;

        // Halt held off while the data access is outstanding
        bus.mem_halt = 1'b1; bus.mem_dren = 1'b1; bus.dhit = 1'b0;
        #1;
        check("halt_wait_ctrl", 32'(ctrl_vec()), 32'(C_FROZEN));
        step();
        check("halt_wait_ctrl2", 32'(ctrl_vec()), 32'(C_FROZEN));
        check("halt_wait_halt", 32'(bus.halt), 32'd0);
        bus.dhit = 1'b1;
        #1;
        check("halt_go_ctrl", 32'(ctrl_vec()), 32'(C_FLOW));
        step();
        bus.mem_halt = 1'b0; bus.mem_dren = 1'b0; bus.dhit = 1'b0;
        #1;
        check("drain_ctrl", 32'(ctrl_vec()), 32'(C_DRAIN));
        check("drain_halt", 32'(bus.halt), 32'd0);
        check("drain_stall", 32'(bus.stall_cycles), 32'd8);
        step();
        check("halted_halt", 32'(bus.halt), 32'd1);
        check("halted_ctrl", 32'(ctrl_vec()), 32'(C_FROZEN));
        check("halted_stall", 32'(bus.stall_cycles), 32'd8);

        // HALTED is sticky regardless of inputs
        for (int i = 0; i < 10; i++) begin
            bus.ihit = 1'($urandom_range(0, 1));
            bus.dhit = 1'($urandom_range(0, 1));
            bus.ex_pcsrc = 1'($urandom_range(0, 1));
            step();
            check("sticky_halt", 32'(bus.halt), 32'd1);
            check("sticky_ctrl", 32'(ctrl_vec()), 32'(C_FROZEN));
            check("sticky_stall", 32'(bus.stall_cycles), 32'd8);
        end

        // Reset leaves HALTED
        idle_inputs();
        RST = 1'b1;
        step();
        check("rst2_halt", 32'(bus.halt), 32'd0);
        check("rst2_stall", 32'(bus.stall_cycles), 32'd0);
        check("rst2_ctrl", 32'(ctrl_vec()), 32'(C_FLOW));
        RST = 1'b0;

        // Reset in the middle of a drain returns to RUN
        bus.mem_halt = 1'b1;
        step();
        bus.mem_halt = 1'b0;
        #1;
        check("mid_drain_ctrl", 32'(ctrl_vec()), 32'(C_DRAIN));
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'(ctrl_vec()), 32'(C_FLOW));
        step();
        check("mid_rst_halt", 32'(bus.halt), 32'd0);
        check("mid_rst_run", 32'(ctrl_vec()), 32'(C_FLOW));

        // Saturation on the 4-bit counter instance with ihit held low
        RST2 = 1'b0;
        #1;
        check("sat_start", 32'(bus2.stall_cycles), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            step();
            check("sat_count", 32'(bus2.stall_cycles), (k > 15) ? 32'd15 : 32'(k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
